hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MDU_LAT, default 32, multiply/divide latency in cycles (range 2..255).
REQ-003 SHALL have ports clk in 1 (clock), rst in 1 (asynchronous, active-high reset).
REQ-004 SHALL have ports RsD, RtD in REG_AW (ID sources); RsE, RtE in REG_AW (EX sources).
REQ-005 SHALL have ports WriteRegEX, WriteRegM, WriteRegWB in REG_AW (stage destinations).
REQ-006 SHALL have ports RegWriteE, RegWriteM, RegWriteWB, MemtoRegEX, MemtoRegM in 1 each.
REQ-007 SHALL have ports branch_ID, branch_taken_ID, jump_ID in 1 each (jump_ID covers j, jal, jr and jalr).
REQ-008 SHALL have ports mdu_start_E in 1 (mult/div entering EX) and hilo_use_D in 1 (ID reads HI/LO or starts an MDU op).
REQ-009 SHALL have outputs ForwardAE, ForwardBE out 2; ForwardAD, ForwardBD out 1.
REQ-010 SHALL have outputs stallF, stallD, flushIDEX, flushIFID, mdu_busy, mdu_done, each out 1.

Function
REQ-011 ForwardAE SHALL be 2'b10 if RsE!=0 and RsE==WriteRegM and RegWriteM; else 2'b01 if RsE!=0 and RsE==WriteRegWB and RegWriteWB; else 2'b00. ForwardBE SHALL follow the same rule using RtE.
REQ-012 ForwardAD SHALL be 1 iff RsD!=0, RsD==WriteRegM and RegWriteM. ForwardBD SHALL follow the same rule using RtD.
REQ-013 lwstall SHALL be MemtoRegEX & RegWriteE & WriteRegEX!=0 & (WriteRegEX==RsD | WriteRegEX==RtD).
REQ-014 branchstall SHALL be branch_ID & (one of):
- RegWriteE & WriteRegEX!=0 & WriteRegEX matches RsD or RtD; or
- MemtoRegM & WriteRegM!=0 & WriteRegM matches RsD or RtD.
REQ-015 mdustall SHALL be hilo_use_D & mdu_busy.
REQ-016 stallF, stallD and flushIDEX SHALL each equal lwstall|branchstall|mdustall (combinational, same cycle).
REQ-017 flushIFID SHALL be (jump_ID | (branch_ID & branch_taken_ID)) & ~stallD.
REQ-018 The MDU tracker SHALL be an FSM with states IDLE, BUSY and DONE, plus an 8-bit down-counter cnt.
REQ-019 IDLE: on mdu_start_E, load cnt=MDU_LAT-1 and go to BUSY.
REQ-020 BUSY: decrement cnt each cycle; when cnt==1, go to DONE.
REQ-021 DONE: lasts one cycle, then go to IDLE; if mdu_start_E is asserted in DONE, reload cnt and go to BUSY.
REQ-022 mdu_busy SHALL be 1 in BUSY and 0 in IDLE and DONE; mdu_done SHALL be 1 only in DONE.
REQ-023 Total busy+done span SHALL be exactly MDU_LAT cycles after the start cycle.
REQ-024 mdu_start_E during BUSY SHALL restart cnt at MDU_LAT-1 (defensive case; the pipeline normally prevents it via mdustall).
REQ-025 All address compares SHALL be full REG_AW bits; no truncation.

Reset
REQ-026 On rst high, the FSM SHALL go to IDLE and cnt to 0 immediately, even mid-operation; mdu_busy and mdu_done SHALL be 0.
REQ-027 Combinational outputs SHALL depend only on inputs and state; after reset with all inputs 0, every output SHALL be 0.
REQ-028 Deassertion SHALL take effect at the first clk rising edge after rst falls.

Configuration
REQ-029 With macro HAZARD_PERF_EN defined, the block SHALL add outputs stall_cnt out 32 and flush_cnt out 32:
- stall_cnt increments on each cycle stallD==1;
- flush_cnt increments on each cycle flushIFID==1;
- both saturate at 32'hFFFFFFFF and clear on rst.
REQ-030 Without HAZARD_PERF_EN, these ports and counters SHALL be absent, with no other behaviour change.

Verification
REQ-031 RsE=3, WriteRegM=3, RegWriteM=1, WriteRegWB=3, RegWriteWB=1 -> ForwardAE=2'b10. Repeat with RsE=0 -> ForwardAE=2'b00.
REQ-032 MemtoRegEX=1, RegWriteE=1, WriteRegEX=5, RtD=5 -> stallF=stallD=flushIDEX=1 and flushIFID=0, even with jump_ID=1. With WriteRegEX=0 -> no stall.
REQ-033 MDU_LAT=4, mdu_start_E pulsed one cycle:
- mdu_busy=1 for the next 3 cycles, then mdu_done=1 for 1 cycle;
- hilo_use_D=1 throughout gives stallD=1 only while mdu_busy=1.
REQ-034 rst asserted on the 2nd busy cycle -> mdu_busy=0 immediately (asynchronous, not waiting for clk); FSM in IDLE; no mdu_done pulse follows.
REQ-035 branch_ID=1, branch_taken_ID=1, no hazards -> flushIFID=1. Then add MemtoRegM=1, WriteRegM=RsD=7 -> stallD=1 and flushIFID=0.
REQ-036 With HAZARD_PERF_EN: 10 stall cycles -> stall_cnt=10. Preload near max -> stall_cnt holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard detection, forwarding select and MDU busy tracking.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegEX,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegWB,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteWB,
  input  logic              MemtoRegEX,
  input  logic              MemtoRegM,
  input  logic              branch_ID,
  input  logic              branch_taken_ID,
  input  logic              jump_ID,
  input  logic              mdu_start_E,
  input  logic              hilo_use_D,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              flushIDEX,
  output logic              flushIFID,
  output logic              mdu_busy,
  output logic              mdu_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [7:0] LOAD = 8'(MDU_LAT - 1);

  mdu_state_t state;
  logic [7:0] cnt;

  logic zs_e, zt_e, zs_d, zt_d;
  logic ex_hit, m_hit;
  logic lwstall, branchstall, mdustall, stall;

  // Forwarding selects: MEM beats WB, register 0 never forwards.
  always_comb begin
    zs_e = RsE != '0;
    zt_e = RtE != '0;
    zs_d = RsD != '0;
    zt_d = RtD != '0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (zs_e && RsE == WriteRegM && RegWriteM)
      ForwardAE = 2'b10;
    else if (zs_e && RsE == WriteRegWB && RegWriteWB)
      ForwardAE = 2'b01;
    if (zt_e && RtE == WriteRegM && RegWriteM)
      ForwardBE = 2'b10;
    else if (zt_e && RtE == WriteRegWB && RegWriteWB)
      ForwardBE = 2'b01;
    ForwardAD = zs_d && RsD == WriteRegM && RegWriteM;
    ForwardBD = zt_d && RtD == WriteRegM && RegWriteM;
  end

  // Stall and flush generation from load-use, branch and MDU hazards.
  always_comb begin
    ex_hit = WriteRegEX != '0 &&
             (WriteRegEX == RsD || WriteRegEX == RtD);
    m_hit  = WriteRegM != '0 &&
             (WriteRegM == RsD || WriteRegM == RtD);
    lwstall     = MemtoRegEX && RegWriteE && ex_hit;
    branchstall = branch_ID &&
                  ((RegWriteE && ex_hit) || (MemtoRegM && m_hit));
    mdustall    = hilo_use_D && mdu_busy;
    stall       = lwstall || branchstall || mdustall;
    stallF      = stall;
    stallD      = stall;
    flushIDEX   = stall;
    flushIFID   = (jump_ID || (branch_ID && branch_taken_ID)) && !stall;
  end

  // MDU latency tracker; a start always reloads the full latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mdu_start_E) begin
            cnt   <= LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mdu_start_E) begin
            cnt <= LOAD;
          end else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1)
              state <= DONE;
          end
        end
        DONE: begin
          if (mdu_start_E) begin
            cnt   <= LOAD;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mdu_busy = state == BUSY;
  assign mdu_done = state == DONE;

`ifdef HAZARD_PERF_EN
  // Saturating event counters for stalls and IF/ID flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallD && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flushIFID && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
